serial_frame_deser: RTL and testbench

- Consumes the registered serial bit stream produced by the team's D flip-flop stage (its `q` drives `din`).
- Hunts for a fixed sync pattern, then deserialises the next WIDTH bits MSB-first into a parallel word.
- Presents each word on a valid/ready output with a one-entry holding register.
- Sits between the bit-level capture flops and word-level consumers.

---
 rtl/serial_frame_deser.sv | 118 +++++++++++
 tb/tb_serial_frame_deser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// Serial frame deserialiser: hunts for a sync pattern, then shifts in one
// MSB-first data word and hands it out through a single-entry valid/ready holding register.
//
// state     | meaning
// S_HUNT    | shifting din through the sync register, waiting for SYNC_PAT
// S_COLLECT | sync seen, shifting WIDTH data bits into the data register
module serial_frame_deser #(
   parameter int               WIDTH    = 8,
   parameter int               SYNC_W   = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             locked,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {S_HUNT, S_COLLECT} state_t;

   state_t            r_state;
   logic [SYNC_W-1:0] r_sync_sr;
   logic [WIDTH-1:0]  r_data_sr;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_dout;
   logic              r_dout_valid;
   logic              r_overflow;

   state_t            w_state_nxt;
   logic [SYNC_W-1:0] w_sync_shift;
   logic [SYNC_W-1:0] w_sync_nxt;
   logic [WIDTH-1:0]  w_data_nxt;
   logic [CW-1:0]     w_cnt_nxt;
   logic              w_done;
   logic              w_accept;

   assign w_sync_shift = {r_sync_sr[SYNC_W-2:0], din};
   assign w_accept     = r_dout_valid && dout_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_sync_nxt  = r_sync_sr;
      w_data_nxt  = r_data_sr;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
      unique case (r_state)
         S_HUNT: begin
            if (din_en) begin
               if (w_sync_shift == SYNC_PAT) begin
                  // Clearing the sync register keeps frames from overlapping.
                  w_state_nxt = S_COLLECT;
                  w_sync_nxt  = '0;
                  w_cnt_nxt   = '0;
               end else begin
                  w_sync_nxt = w_sync_shift;
               end
            end
         end
         S_COLLECT: begin
            if (din_en) begin
               w_data_nxt = {r_data_sr[WIDTH-2:0], din};
               if (r_cnt == CW'(WIDTH - 1)) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_HUNT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_HUNT;
         r_sync_sr    <= '0;
         r_data_sr    <= '0;
         r_cnt        <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sync_sr <= w_sync_nxt;
         r_data_sr <= w_data_nxt;
         r_cnt     <= w_cnt_nxt;
         if (w_done) begin
            if (!r_dout_valid || dout_ready) begin
               r_dout       <= w_data_nxt;
               r_dout_valid <= 1'b1;
            end else begin
               r_overflow <= 1'b1;
            end
         end else if (w_accept) begin
            r_dout_valid <= 1'b0;
         end
         // A drop on the same edge as a clear leaves the flag set.
         if (ovf_clr && !(w_done && r_dout_valid && !dout_ready)) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign locked     = (r_state == S_COLLECT);
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser: hand-computed frames, each check is
// an immediate assertion sampled 1 time unit after the rising edge.
module tb_serial_frame_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       din_en;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       locked;
   logic       overflow;
   logic       ovf_clr;

   int n_vec = 0;
   int n_err = 0;

   serial_frame_deser #(.WIDTH(8), .SYNC_W(8), .SYNC_PAT(8'hA5)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_en     (din_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .locked     (locked),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      din_en = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_bit(input logic b);
      din    = b;
      din_en = 1'b1;
      tick();
      din_en = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit gaps);
      for (int i = 7; i >= 0; i--) begin
         send_bit(v[i]);
         if (gaps) idle(1);
      end
   endtask

   initial begin
      rst = 1'b1; din = 1'b0; din_en = 1'b0; dout_ready = 1'b0; ovf_clr = 1'b0;

      // Reset then idle
      tick(); tick();
      rst = 1'b0;
      idle(5);
      chk("rst_dout",  32'(dout), 32'h0);
      chk("rst_valid", 32'(dout_valid), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_ovf",   32'(overflow), 32'h0);

      // Basic frame, continuous enable
      dout_ready = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         logic [7:0] s;
         s = 8'hA5;
         send_bit(s[i]);
      end
      chk("basic_nolock_7", 32'(locked), 32'h0);
      send_bit(1'b1);
      chk("basic_lock_8", 32'(locked), 32'h1);
      for (int i = 7; i >= 1; i--) begin
         logic [7:0] d;
         d = 8'h3C;
         send_bit(d[i]);
      end
      chk("basic_valid_15", 32'(dout_valid), 32'h0);
      send_bit(1'b0);
      chk("basic_valid_16", 32'(dout_valid), 32'h1);
      chk("basic_dout", 32'(dout), 32'h3C);
      chk("basic_unlock", 32'(locked), 32'h0);
      idle(1);
      chk("basic_valid_drop", 32'(dout_valid), 32'h0);
      chk("basic_dout_hold", 32'(dout), 32'h3C);

      // False sync and gaps
      send_byte(8'hA4, 1'b1);
      chk("false_nolock", 32'(locked), 32'h0);
      send_byte(8'hA5, 1'b1);
      chk("gap_lock", 32'(locked), 32'h1);
      send_byte(8'hF0, 1'b1);
      chk("gap_valid", 32'(dout_valid), 32'h0);
      chk("gap_dout", 32'(dout), 32'hF0);
      chk("gap_unlock", 32'(locked), 32'h0);

      // Same bytes, checking the completion cycle itself
      send_byte(8'hA5, 1'b1);
      send_byte(8'hF0, 1'b0);
      chk("nogap_valid", 32'(dout_valid), 32'h1);
      chk("nogap_dout", 32'(dout), 32'hF0);
      idle(1);

      // Backpressure / overflow
      dout_ready = 1'b0;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h11, 1'b0);
      chk("bp_valid1", 32'(dout_valid), 32'h1);
      chk("bp_dout1", 32'(dout), 32'h11);
      chk("bp_ovf0", 32'(overflow), 32'h0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h22, 1'b0);
      chk("bp_dout_held", 32'(dout), 32'h11);
      chk("bp_ovf1", 32'(overflow), 32'h1);
      dout_ready = 1'b1;
      idle(1);
      chk("bp_drain", 32'(dout_valid), 32'h0);
      chk("bp_ovf_sticky", 32'(overflow), 32'h1);
      ovf_clr = 1'b1;
      idle(1);
      ovf_clr = 1'b0;
      chk("bp_ovf_clr", 32'(overflow), 32'h0);

      // Overflow set and clear on the same edge: set wins
      dout_ready = 1'b0;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'hA5, 1'b0);
      for (int i = 7; i >= 1; i--) begin
         logic [7:0] d;
         d = 8'h44;
         send_bit(d[i]);
      end
      ovf_clr = 1'b1;
      send_bit(1'b0);
      ovf_clr = 1'b0;
      chk("setclr_ovf", 32'(overflow), 32'h1);
      chk("setclr_dout", 32'(dout), 32'h33);
      ovf_clr = 1'b1;
      dout_ready = 1'b1;
      idle(1);
      ovf_clr = 1'b0;
      chk("setclr_cleared", 32'(overflow), 32'h0);

      // Simultaneous accept and complete
      dout_ready = 1'b0;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'hA5, 1'b0);
      for (int i = 7; i >= 1; i--) begin
         logic [7:0] d;
         d = 8'h22;
         send_bit(d[i]);
      end
      chk("sim_pre_dout", 32'(dout), 32'h11);
      dout_ready = 1'b1;
      send_bit(1'b0);
      chk("sim_dout", 32'(dout), 32'h22);
      chk("sim_valid", 32'(dout_valid), 32'h1);
      chk("sim_ovf", 32'(overflow), 32'h0);
      idle(1);
      chk("sim_drain", 32'(dout_valid), 32'h0);

      // Reset mid-frame
      dout_ready = 1'b0;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk("mid_locked", 32'(locked), 32'h1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("mid_rst_locked", 32'(locked), 32'h0);
      chk("mid_rst_valid", 32'(dout_valid), 32'h0);
      chk("mid_rst_dout", 32'(dout), 32'h0);
      dout_ready = 1'b1;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h5A, 1'b0);
      chk("mid_valid", 32'(dout_valid), 32'h1);
      chk("mid_dout", 32'(dout), 32'h5A);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
